// File: rtl/instr_encoder.sv
// Field-to-word instruction encoder: packs decoded fields into 16-bit words and writes them
// to instruction RAM at an auto-incrementing address until DEPTH words have been stored.
module instr_encoder #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        aluop,
    input  logic [2:0]        op1,
    input  logic [2:0]        op2,
    input  logic [7:0]        immdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StWrite, StFull} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W:0]     count_inc;
    logic [15:0]         wdata_q, wdata_d;
    logic                err_q, err_d;

    logic [8:0]          opc;
    logic [3:0]          imm_idx;
    logic [15:0]         enc_word;

    // Register-format opcodes skip 7 and 17, so aluop shifts up by one past each gap.
    always_comb begin
        opc = {4'd0, aluop};
        if (aluop >= 5'd16) begin
            opc = {4'd0, aluop} + 9'd2;
        end else if (aluop >= 5'd7) begin
            opc = {4'd0, aluop} + 9'd1;
        end
        imm_idx = 4'(aluop - 5'd19);
        if (aluop <= 5'd18) begin
            enc_word = {1'b0, opc, op1, op2};
        end else begin
            enc_word = {1'b1, imm_idx, op1, immdata};
        end
    end

    assign in_ready  = (state_q == StIdle) && !clear;
    assign mem_we    = (state_q == StWrite);
    assign full      = (state_q == StFull);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign count     = count_q;
    assign err       = err_q;
    assign count_inc = count_q + (ADDR_W + 1)'(1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        if (clear) begin
            // Restart wins over any write completing in the same cycle.
            state_d = StIdle;
            addr_d  = '0;
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid && in_ready) begin
                        if (aluop == 5'd31) begin
                            err_d = 1'b1;
                        end else begin
                            wdata_d = enc_word;
                            state_d = StWrite;
                        end
                    end
                end
                StWrite: begin
                    if (mem_ack) begin
                        count_d = count_inc;
                        // Hold the address at DEPTH-1 when full so it never wraps.
                        if (count_inc == DepthCnt) begin
                            state_d = StFull;
                        end else begin
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = StIdle;
                        end
                    end
                end
                StFull: begin
                    state_d = StFull;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            count_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: transaction-level reference model checked every cycle, plus
// hand-computed encodings, stall, error/clear and full-boundary scenarios.
module tb_instr_encoder;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clear = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [4:0]        aluop = '0;
    logic [2:0]        op1 = '0;
    logic [2:0]        op2 = '0;
    logic [7:0]        immdata = '0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_ack = 1'b0;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;

    int tests = 0;
    int fails = 0;
    int ack_mode = 1;  // 0: ack low, 1: ack high, 2: random
    bit cmp_en = 1'b0;

    // Reference model state
    int opc_tab[19];
    bit m_pending = 1'b0;
    int m_count = 0;
    bit m_err = 1'b0;
    logic [15:0] m_word = '0;

    instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluop     (aluop),
        .op1       (op1),
        .op2       (op2),
        .immdata   (immdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .count     (count),
        .full      (full),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_word(input int a, input int r1, input int r2,
                                               input int imm);
        if (a <= 18) return 16'(opc_tab[a] * 64 + r1 * 8 + r2);
        return 16'(32768 + (a - 19) * 2048 + r1 * 256 + imm);
    endfunction

    // Reference model: advances on every rising edge from the inputs seen at that edge.
    initial begin
        forever begin
            @(posedge clk);
            if (rst || clear) begin
                m_pending = 1'b0;
                m_count   = 0;
                m_err     = 1'b0;
                if (rst) m_word = '0;
            end else if (m_pending) begin
                if (mem_ack) begin
                    m_pending = 1'b0;
                    m_count++;
                end
            end else if (in_valid && m_count < DEPTH) begin
                if (aluop == 5'd31) begin
                    m_err = 1'b1;
                end else begin
                    m_pending = 1'b1;
                    m_word = model_word(int'(aluop), int'(op1), int'(op2), int'(immdata));
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("in_ready", 32'(in_ready), 32'(!m_pending && m_count < DEPTH && !clear));
                check("mem_we", 32'(mem_we), 32'(m_pending));
                check("count", 32'(count), 32'(m_count));
                check("full", 32'(full), 32'(m_count == DEPTH));
                check("err", 32'(err), 32'(m_err));
                if (m_pending) begin
                    check("mem_addr", 32'(mem_addr), 32'(m_count));
                    check("mem_wdata", 32'(mem_wdata), 32'(m_word));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (ack_mode)
                0: mem_ack = 1'b0;
                1: mem_ack = 1'b1;
                default: mem_ack = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send(input int a, input int r1, input int r2, input int imm,
                        input int budget, output bit acc);
        bit rdy;
        aluop    = 5'(a);
        op1      = 3'(r1);
        op2      = 3'(r2);
        immdata  = 8'(imm);
        in_valid = 1'b1;
        acc      = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                acc = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_req(input string name, input int a, input int r1, input int r2,
                            input int imm);
        bit acc;
        send(a, r1, r2, imm, 20, acc);
        check({name, "_accepted"}, 32'(acc), 32'd1);
    endtask

    task automatic wait_write(input string name, input logic [15:0] word, input int addr);
        bit got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_we) begin
                got = 1'b1;
                break;
            end
        end
        check({name, "_we_seen"}, 32'(got), 32'd1);
        check({name, "_wdata"}, 32'(mem_wdata), 32'(word));
        check({name, "_addr"}, 32'(mem_addr), 32'(addr));
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        int k = 0;
        bit acc;
        for (int v = 0; v <= 20; v++) begin
            if (v != 7 && v != 17) begin
                opc_tab[k] = v;
                k++;
            end
        end

        rst = 1'b1;
        @(posedge clk);
        cmp_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0000);
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;

        // Hand-computed encodings
        send_req("add", 1, 3, 5, 8'hAA);
        wait_write("add", 16'h005D, 0);
        @(negedge clk);
        check("add_count", 32'(count), 32'd1);
        check("add_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        clear_pulse();
        send_req("not", 7, 2, 0, 8'h55);
        wait_write("not", 16'h0210, 0);
        send_req("cmp", 18, 1, 2, 8'h00);
        wait_write("cmp", 16'h050A, 1);
        clear_pulse();
        send_req("jmp", 24, 0, 7, 8'h3C);
        wait_write("jmp", 16'hA83C, 0);
        send_req("li", 25, 4, 3, 8'h7F);
        wait_write("li", 16'hB47F, 1);
        send_req("showdmseg", 30, 0, 5, 8'h00);
        wait_write("showdmseg", 16'hD800, 2);
        clear_pulse();

        // Stall: RAM withholds ack for five cycles
        ack_mode = 0;
        send_req("stall", 1, 3, 5, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_we", 32'(mem_we), 32'd1);
            check("stall_wdata", 32'(mem_wdata), 32'h005D);
            check("stall_addr", 32'(mem_addr), 32'd0);
            check("stall_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        ack_mode = 1;
        @(posedge clk);
        @(negedge clk);
        check("stall_count", 32'(count), 32'd1);
        check("stall_ready_after", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Error, then clear during a write with ack high
        clear_pulse();
        send_req("bad_op", 31, 1, 1, 1);
        @(negedge clk);
        check("bad_we", 32'(mem_we), 32'd0);
        check("bad_err", 32'(err), 32'd1);
        check("bad_count", 32'(count), 32'd0);
        @(posedge clk);
        #1;
        send_req("clr_wr", 1, 3, 5, 0);
        clear_pulse();
        @(negedge clk);
        check("clr_addr", 32'(mem_addr), 32'd0);
        check("clr_count", 32'(count), 32'd0);
        check("clr_err", 32'(err), 32'd0);
        check("clr_we", 32'(mem_we), 32'd0);
        @(posedge clk);
        #1;

        // Fill to DEPTH, then a fifth request must stall
        for (int i = 0; i < DEPTH; i++) begin
            send_req("fill", 2 * i + 3, i, 7 - i, 16 * i);
            wait_write("fill", model_word(2 * i + 3, i, 7 - i, 16 * i), i);
        end
        @(negedge clk);
        check("full_flag", 32'(full), 32'd1);
        check("full_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        send(20, 1, 1, 9, 8, acc);
        check("fifth_rejected", 32'(acc), 32'd0);
        clear_pulse();
        @(negedge clk);
        check("unfull_flag", 32'(full), 32'd0);
        check("unfull_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Randomized traffic; the per-cycle model check covers it
        ack_mode = 2;
        for (int n = 0; n < 400; n++) begin
            int r = $urandom_range(0, 99);
            if (r < 6) begin
                clear_pulse();
            end else if (r < 8) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end else begin
                send($urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 255), 12, acc);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end

        repeat (4) @(posedge clk);
        #1;
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
